// File: rtl/main_memory_ctrl.sv
// Byte-addressed main memory with fixed access latency, single READ/WRITE and READ_BURST.
// Optional macro MEM_ALIGN_CHECK_EN rejects requests whose address is not word aligned.
module main_memory_ctrl #(
  parameter int ADDR_WIDTH      = 17,
  parameter int LEN             = 32,
  parameter int BYTE_SIZE       = 8,
  parameter int BURST_LEN       = 8,
  parameter int BEAT_INDEX_SIZE = 3,
  parameter int ACCESS_LATENCY  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 mem_vis_signal,
  input  logic [ADDR_WIDTH-1:0]      mem_vis_addr,
  input  logic [LEN-1:0]             mem_writen_data,
  output logic [LEN-1:0]             mem_data,
  output logic [1:0]                 mem_status,
  output logic [BEAT_INDEX_SIZE-1:0] mem_beat_index
);

  localparam int BPW = LEN / BYTE_SIZE;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] OP_BURST = 2'd3;

  localparam logic [1:0] ST_RESTING = 2'd0;
  localparam logic [1:0] ST_WORKING = 2'd1;
  localparam logic [1:0] ST_READY   = 2'd2;
`ifdef MEM_ALIGN_CHECK_EN
  localparam logic [1:0] ST_ERROR   = 2'd3;
`endif

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER} state_e;

  logic [BYTE_SIZE-1:0]       mem_q [0:(1<<ADDR_WIDTH)-1];
  state_e                     state_q;
  logic [1:0]                 op_q;
  logic [ADDR_WIDTH-1:0]      addr_q;
  logic [LEN-1:0]             wdata_q;
  logic [3:0]                 lat_q;
  logic [BEAT_INDEX_SIZE-1:0] beat_q;
  logic [LEN-1:0]             data_q;
  logic [1:0]                 status_q;
  logic [BEAT_INDEX_SIZE-1:0] idx_q;

  logic [ADDR_WIDTH-1:0]      beat_addr_d;
  logic [LEN-1:0]             rd_word_d;
  logic                       wr_en_d;

  // Address arithmetic wraps naturally at ADDR_WIDTH bits.
  always_comb begin
    beat_addr_d = addr_q + ADDR_WIDTH'(BPW * int'(beat_q));
    rd_word_d   = '0;
    for (int b = 0; b < BPW; b++)
      rd_word_d[b*BYTE_SIZE +: BYTE_SIZE] = mem_q[beat_addr_d + ADDR_WIDTH'(b)];
    wr_en_d = (state_q == S_XFER) && (op_q == OP_WRITE);
  end

  // Storage is deliberately not reset; an aborted write never reaches XFER.
  always_ff @(posedge clk) begin
    if (wr_en_d)
      for (int b = 0; b < BPW; b++)
        mem_q[addr_q + ADDR_WIDTH'(b)] <= wdata_q[b*BYTE_SIZE +: BYTE_SIZE];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= OP_NOP;
      addr_q   <= '0;
      wdata_q  <= '0;
      lat_q    <= '0;
      beat_q   <= '0;
      data_q   <= '0;
      status_q <= ST_RESTING;
      idx_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          status_q <= ST_RESTING;
          idx_q    <= '0;
          // Gating on RESTING guarantees one idle cycle after READY/ERROR.
          if (status_q == ST_RESTING && mem_vis_signal != OP_NOP) begin
`ifdef MEM_ALIGN_CHECK_EN
            if (mem_vis_addr[1:0] != 2'b00) begin
              status_q <= ST_ERROR;
            end else
`endif
            begin
              op_q     <= mem_vis_signal;
              addr_q   <= mem_vis_addr;
              wdata_q  <= mem_writen_data;
              lat_q    <= 4'(ACCESS_LATENCY - 1);
              beat_q   <= '0;
              status_q <= ST_WORKING;
              state_q  <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (lat_q == 4'd0) state_q <= S_XFER;
          else               lat_q   <= lat_q - 4'd1;
        end
        S_XFER: begin
          status_q <= ST_READY;
          idx_q    <= beat_q;
          if (op_q != OP_WRITE) data_q <= rd_word_d;
          if (op_q == OP_BURST && beat_q != BEAT_INDEX_SIZE'(BURST_LEN - 1)) begin
            beat_q <= beat_q + 1'b1;
          end else begin
            beat_q  <= '0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_data       = data_q;
  assign mem_status     = status_q;
  assign mem_beat_index = idx_q;

endmodule
